rr_arbiter_sync: RTL and testbench

//  Clocked NREQ-way round-robin arbiter. It shares one downstream 4-phase bundled-data channel
//  (r/a/d, return-to-zero) between NREQ upstream 4-phase channels.

---
 rtl/rr_arbiter_sync.sv | 180 ++++++++++++++++++
 tb/tb_rr_arbiter_sync.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_sync.sv
// -----------------------------------------------------------------------------
// rr_arbiter_sync
//
// Clocked NREQ-way round-robin arbiter. It shares one downstream 4-phase
// (return-to-zero) bundled-data channel between NREQ upstream 4-phase
// channels. Only one handshake is in flight at a time. The granted
// requester's data is captured into a register when the grant is issued and
// held stable for the whole downstream handshake. Every output comes from a
// register, so there is no combinational path from any input to any output.
//
// Ports
//   clk    in   1        clock, rising edge
//   rst    in   1        asynchronous reset, active low
//   r_i    in   NREQ     per-requester 4-phase request
//   a_i    out  NREQ     per-requester acknowledge, one-hot or zero
//   d_i    in   NREQ*N   requester k data at d_i[k*N +: N]
//   r_o    out  1        downstream request
//   a_o    in   1        downstream acknowledge
//   d_o    out  N        downstream data, registered
//   gnt_o  out  NREQ     one-hot current grant, zero when idle
//
// Build option
//   SYNC_INPUTS_EN : when defined, r_i and a_o each pass through a 2-flop
//   synchronizer, so every handshake latency grows by two clock edges.
//   d_i is never synchronized; the source is trusted to present data
//   before raising its request (bundled-data timing).
// -----------------------------------------------------------------------------
module rr_arbiter_sync #(
  parameter int NREQ   = 4,
  parameter int N      = 8,
  parameter int NATIVE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   r_i,
  output logic [NREQ-1:0]   a_i,
  input  logic [NREQ*N-1:0] d_i,
  output logic              r_o,
  input  logic              a_o,
  output logic [N-1:0]      d_o,
  output logic [NREQ-1:0]   gnt_o
);

  // NATIVE has no functional effect here; it is folded in as zero so the
  // parameter stays part of the interface.
  localparam int IW = $clog2(NREQ) + 0 * NATIVE;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD,
    REL
  } state_e;

  state_e          state_q;
  logic [IW-1:0]   ptr_q;
  logic [IW-1:0]   idx_q;
  logic [NREQ-1:0] gnt_q;
  logic [NREQ-1:0] ack_q;
  logic            reqOut_q;
  logic [N-1:0]    data_q;

  logic [NREQ-1:0] r_s;
  logic            a_s;

`ifdef SYNC_INPUTS_EN
  // Two-flop synchronizers on the handshake wires only.
  logic [NREQ-1:0] rMeta_q;
  logic [NREQ-1:0] rSync_q;
  logic            aMeta_q;
  logic            aSync_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rMeta_q <= '0;
      rSync_q <= '0;
      aMeta_q <= 1'b0;
      aSync_q <= 1'b0;
    end else begin
      rMeta_q <= r_i;
      rSync_q <= rMeta_q;
      aMeta_q <= a_o;
      aSync_q <= aMeta_q;
    end
  end

  assign r_s = rSync_q;
  assign a_s = aSync_q;
`else
  assign r_s = r_i;
  assign a_s = a_o;
`endif

  // Round-robin pick. Candidates are scanned from the lowest priority
  // (ptr+NREQ-1) up to the highest (ptr), so the last hit written wins and
  // no "found" flag is needed. cand is one bit wider than ptr so the
  // wrap-around subtraction is exact for non-power-of-two NREQ.
  logic [IW-1:0] pickIdx;
  logic          pickValid;
  logic [IW:0]   cand;

  always_comb begin
    pickIdx   = '0;
    pickValid = 1'b0;
    cand      = '0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      cand = {1'b0, ptr_q} + (IW + 1)'(off);
      if (cand >= (IW + 1)'(NREQ)) begin
        cand = cand - (IW + 1)'(NREQ);
      end
      if (r_s[cand[IW-1:0]]) begin
        pickIdx   = cand[IW-1:0];
        pickValid = 1'b1;
      end
    end
  end

  logic [NREQ-1:0] pickOneHot;
  logic [N-1:0]    pickData;
  logic [IW-1:0]   ptr_d;

  assign pickOneHot = {{(NREQ - 1){1'b0}}, 1'b1} << pickIdx;
  assign pickData   = d_i[int'(pickIdx) * N +: N];
  // Pointer moves just past the requester that was served.
  assign ptr_d      = (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + 1'b1;

  // Handshake FSM. All outputs are registers updated here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      idx_q    <= '0;
      gnt_q    <= '0;
      ack_q    <= '0;
      reqOut_q <= 1'b0;
      data_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pickValid) begin
            gnt_q    <= pickOneHot;
            idx_q    <= pickIdx;
            data_q   <= pickData;
            reqOut_q <= 1'b1;
            state_q  <= REQ;
          end
        end
        // A requester dropping r_i here is ignored; the downstream
        // request already issued is carried through to its acknowledge.
        REQ: begin
          if (a_s) begin
            ack_q   <= gnt_q;
            state_q <= HOLD;
          end
        end
        HOLD: begin
          if (!r_s[idx_q]) begin
            reqOut_q <= 1'b0;
            state_q  <= REL;
          end
        end
        REL: begin
          if (!a_s) begin
            ack_q   <= '0;
            gnt_q   <= '0;
            ptr_q   <= ptr_d;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign a_i   = ack_q;
  assign r_o   = reqOut_q;
  assign d_o   = data_q;
  assign gnt_o = gnt_q;

endmodule

// File: tb/tb_rr_arbiter_sync.sv
// -----------------------------------------------------------------------------
// tb_rr_arbiter_sync
//
// Directed bench for rr_arbiter_sync (NREQ=4, N=8). Inputs are driven one
// time unit after each rising edge and outputs are sampled there too, well
// away from the active edge. LAT is the number of edges between an input
// change and the registered reaction; it is 3 when SYNC_INPUTS_EN is
// defined and 1 otherwise.
// -----------------------------------------------------------------------------
module tb_rr_arbiter_sync;

`ifdef SYNC_INPUTS_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic        clk;
  logic        rst;
  logic [3:0]  rIn;
  logic [3:0]  aUp;
  logic [31:0] dIn;
  logic        rOut;
  logic        aDown;
  logic [7:0]  dOut;
  logic [3:0]  gnt;

  int compared;
  int mismatched;

  rr_arbiter_sync #(
    .NREQ  (4),
    .N     (8),
    .NATIVE(1)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .r_i  (rIn),
    .a_i  (aUp),
    .d_i  (dIn),
    .r_o  (rOut),
    .a_o  (aDown),
    .d_o  (dOut),
    .gnt_o(gnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [3:0] rVal, input logic aVal, input logic [31:0] dVal);
    rIn   = rVal;
    aDown = aVal;
    dIn   = dVal;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Runs one granted handshake to completion, starting just after r_o rose.
  // rHold is the request vector applied to release (bit k must be 0),
  // rAfter is applied once the acknowledge has returned to zero.
  task automatic runCycle(input int k, input logic [7:0] expD,
                          input logic [3:0] rHold, input logic [3:0] rAfter);
    logic [31:0] oh;
    oh = 32'd1 << k;
    checkOutput("cyc_gnt", 32'(gnt), oh);
    checkOutput("cyc_dout", 32'(dOut), 32'(expD));
    checkOutput("cyc_ai_req", 32'(aUp), 32'd0);
    aDown = 1'b1;
    tick(LAT);
    checkOutput("cyc_ai_ack", 32'(aUp), oh);
    checkOutput("cyc_ro_hold", 32'(rOut), 32'd1);
    rIn = rHold;
    tick(LAT);
    checkOutput("cyc_ro_rel", 32'(rOut), 32'd0);
    checkOutput("cyc_ai_rel", 32'(aUp), oh);
    checkOutput("cyc_dout_rel", 32'(dOut), 32'(expD));
    aDown = 1'b0;
    tick(LAT);
    checkOutput("cyc_ai_idle", 32'(aUp), 32'd0);
    checkOutput("cyc_gnt_idle", 32'(gnt), 32'd0);
    rIn = rAfter;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst        = 1'b0;
    applyStimulus(4'b0000, 1'b0, 32'h0);

    // Reset state before any clock edge.
    #1;
    checkOutput("rst_ro", 32'(rOut), 32'd0);
    checkOutput("rst_ai", 32'(aUp), 32'd0);
    checkOutput("rst_gnt", 32'(gnt), 32'd0);
    checkOutput("rst_dout", 32'(dOut), 32'd0);
    tick(2);
    rst = 1'b1;
    tick(3);
    checkOutput("idle_ro", 32'(rOut), 32'd0);

    // T2: single request from requester 2, downstream acks after 3 clocks.
    applyStimulus(4'b0100, 1'b0, 32'h44A52211);
    tick(LAT - 1);
    checkOutput("t2_ro_early", 32'(rOut), 32'd0);
    tick(1);
    checkOutput("t2_ro", 32'(rOut), 32'd1);
    checkOutput("t2_dout", 32'(dOut), 32'hA5);
    checkOutput("t2_gnt", 32'(gnt), 32'b0100);
    tick(3);
    checkOutput("t2_ai_wait", 32'(aUp), 32'd0);
    checkOutput("t2_ro_wait", 32'(rOut), 32'd1);
    aDown = 1'b1;
    tick(LAT - 1);
    checkOutput("t2_ai_early", 32'(aUp), 32'd0);
    tick(1);
    checkOutput("t2_ai", 32'(aUp), 32'b0100);
    rIn = 4'b0000;
    tick(LAT);
    checkOutput("t2_ro_fall", 32'(rOut), 32'd0);
    checkOutput("t2_ai_hold", 32'(aUp), 32'b0100);
    aDown = 1'b0;
    tick(LAT);
    checkOutput("t2_ai_fall", 32'(aUp), 32'd0);
    checkOutput("t2_gnt_fall", 32'(gnt), 32'd0);

    // T4: ptr is now 3; requesters 3 and 0 arrive together -> 3 then 0.
    applyStimulus(4'b1001, 1'b0, 32'h3300_0000 | 32'h0000_0030);
    tick(LAT);
    checkOutput("t4_ro1", 32'(rOut), 32'd1);
    runCycle(3, 8'h33, 4'b0001, 4'b0001);
    tick(1);
    checkOutput("t4_ro2", 32'(rOut), 32'd1);
    runCycle(0, 8'h30, 4'b0000, 4'b0000);

    // T5: requester 0 holds the grant while requester 1 pulses for 1 clk.
    applyStimulus(4'b0001, 1'b0, 32'h0000_4B5A);
    tick(LAT);
    checkOutput("t5_gnt", 32'(gnt), 32'b0001);
    checkOutput("t5_dout", 32'(dOut), 32'h5A);
    aDown = 1'b1;
    tick(LAT);
    checkOutput("t5_ai", 32'(aUp), 32'b0001);
    rIn = 4'b0011;
    tick(1);
    rIn = 4'b0001;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      checkOutput("t5_gnt_hold", 32'(gnt), 32'b0001);
      checkOutput("t5_ai_hold", 32'(aUp), 32'b0001);
    end
    rIn = 4'b0000;
    tick(LAT);
    checkOutput("t5_ro_fall", 32'(rOut), 32'd0);
    aDown = 1'b0;
    tick(LAT);
    checkOutput("t5_ai_fall", 32'(aUp), 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick(1);
      checkOutput("t5_no_gnt1", 32'(gnt), 32'd0);
      checkOutput("t5_ro_idle", 32'(rOut), 32'd0);
    end

    // T1: asynchronous reset in the middle of REQ with r_o high.
    applyStimulus(4'b0010, 1'b0, 32'h0000_5C00);
    tick(LAT);
    checkOutput("t1_ro_pre", 32'(rOut), 32'd1);
    checkOutput("t1_gnt_pre", 32'(gnt), 32'b0010);
    checkOutput("t1_dout_pre", 32'(dOut), 32'h5C);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("t1_ro_async", 32'(rOut), 32'd0);
    checkOutput("t1_ai_async", 32'(aUp), 32'd0);
    checkOutput("t1_gnt_async", 32'(gnt), 32'd0);
    checkOutput("t1_dout_async", 32'(dOut), 32'd0);
    rIn = 4'b0000;
    #2;
    rst = 1'b1;
    tick(4);
    checkOutput("t1_ro_after", 32'(rOut), 32'd0);
    checkOutput("t1_gnt_after", 32'(gnt), 32'd0);

    // T3: all four hold requests; each re-requests after its handshake.
    applyStimulus(4'b1111, 1'b0, 32'hD3C2B1A0);
    tick(LAT);
    checkOutput("t3_ro0", 32'(rOut), 32'd1);
    runCycle(0, 8'hA0, 4'b1110, 4'b1111);
    tick(1);
    checkOutput("t3_ro1", 32'(rOut), 32'd1);
    runCycle(1, 8'hB1, 4'b1101, 4'b1111);
    tick(1);
    checkOutput("t3_ro2", 32'(rOut), 32'd1);
    runCycle(2, 8'hC2, 4'b1011, 4'b1111);
    tick(1);
    checkOutput("t3_ro3", 32'(rOut), 32'd1);
    runCycle(3, 8'hD3, 4'b0111, 4'b1111);
    tick(1);
    checkOutput("t3_ro4", 32'(rOut), 32'd1);
    runCycle(0, 8'hA0, 4'b0000, 4'b0000);

    // T6: downstream stalls for 100 clocks in REQ while others request
    // and the data inputs change.
    applyStimulus(4'b0100, 1'b0, 32'h0077_0000);
    tick(LAT);
    checkOutput("t6_ro", 32'(rOut), 32'd1);
    checkOutput("t6_gnt", 32'(gnt), 32'b0100);
    applyStimulus(4'b1111, 1'b0, 32'hFFFF_FFFF);
    for (int i = 0; i < 100; i++) begin
      tick(1);
      checkOutput("t6_ro_stall", 32'(rOut), 32'd1);
      checkOutput("t6_dout_stall", 32'(dOut), 32'h77);
      checkOutput("t6_ai_stall", 32'(aUp), 32'd0);
      checkOutput("t6_gnt_stall", 32'(gnt), 32'b0100);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
